riscv_uart_loader: RTL

Bus initiator that streams a program image from a UART line into data memory. It drives the same write port the CPU store path uses (cache_d_write_en / cache_d_write / addr / data_to_cache) on the io bridge. It holds the CPU while loading and reports done/error status.

---
 rtl/riscv_uart_loader_pkg.sv | 29 ++
 rtl/riscv_uart_loader_if.sv | 15 +
 rtl/riscv_uart_rx_byte.sv | 90 +++++++++
 rtl/riscv_uart_loader.sv | 139 +++++++++++++
 4 files changed

// File: rtl/riscv_uart_loader_pkg.sv
// Shared encodings for the UART program loader: loader/receiver state enums
// and the store-path write type reused from the CPU data cache port.
package riscv_uart_loader_pkg;

  localparam int CACHE_D_WRITE_LEN = 3;
  localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SW = 3'd3;

  typedef enum logic [2:0] {
    LOADER_IDLE  = 3'd0,
    LOADER_LEN   = 3'd1,
    LOADER_DATA  = 3'd2,
    LOADER_WRITE = 3'd3,
    LOADER_DONE  = 3'd4,
    LOADER_ERR   = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Byte address of a word slot; wraps at 32 bits like the CPU address adder.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/riscv_uart_loader_if.sv
// Write port into the io bridge, identical to the CPU store path.
interface riscv_uart_loader_if;
  import riscv_uart_loader_pkg::*;

  // Strobe-only handshake: the bridge accepts a write in any cycle where
  // cache_d_write_en is 1 (no ready); addr/data_to_cache are valid only then.
  logic                         cache_d_write_en;
  logic [CACHE_D_WRITE_LEN-1:0] cache_d_write;
  logic [31:0]                  addr;
  logic [31:0]                  data_to_cache;

  modport master (output cache_d_write_en, cache_d_write, addr, data_to_cache);
  modport slave  (input  cache_d_write_en, cache_d_write, addr, data_to_cache);

endinterface

// File: rtl/riscv_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid on a good stop bit and one-cycle frame_err on a bad one.
module riscv_uart_rx_byte
  import riscv_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_s;

  assign rx_s = sync[1];

  // Synchronizer resets high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync       <= 2'b11;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], uart_rx};
      rx_prev    <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_uart_loader.sv
// Streams a length-prefixed little-endian word image from the UART into data
// memory through the store write port, holding the CPU (busy) while loading.
module riscv_uart_loader
  import riscv_uart_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  input  logic                 start,
  riscv_uart_loader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output loader_state_t        loader_state,
  output rx_state_t            rx_state
);

  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic        frame_err;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] next_word;
  logic [31:0] len_n;
  logic [31:0] word_idx;
  logic        wen;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  riscv_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err),
    .state      (rx_state)
  );

  // Bytes arrive LSB first, so each new byte enters at the top.
  assign next_word = {rx_byte, asm_word[31:8]};

  assign bus.cache_d_write_en = wen;
  assign bus.cache_d_write    = CACHE_D_WRITE_SW;
  assign bus.addr             = addr_q;
  assign bus.data_to_cache    = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loader_state <= LOADER_IDLE;
      byte_cnt     <= '0;
      asm_word     <= '0;
      len_n        <= '0;
      word_idx     <= '0;
      wen          <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      wen <= 1'b0;
      case (loader_state)
        LOADER_IDLE, LOADER_DONE, LOADER_ERR: begin
          if (start) begin
            loader_state <= LOADER_LEN;
            byte_cnt     <= '0;
            word_idx     <= '0;
            asm_word     <= '0;
            len_n        <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
          end
        end
        LOADER_LEN: begin
          if (frame_err) begin
            loader_state <= LOADER_ERR;
            busy         <= 1'b0;
            err          <= 1'b1;
          end else if (byte_valid) begin
            asm_word <= next_word;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              len_n <= next_word;
              if (next_word == 32'd0) begin
                loader_state <= LOADER_DONE;
                busy         <= 1'b0;
                done         <= 1'b1;
              end else if (next_word > 32'(MAX_WORDS)) begin
                loader_state <= LOADER_ERR;
                busy         <= 1'b0;
                err          <= 1'b1;
              end else begin
                loader_state <= LOADER_DATA;
              end
            end
          end
        end
        LOADER_DATA: begin
          if (frame_err) begin
            loader_state <= LOADER_ERR;
            busy         <= 1'b0;
            err          <= 1'b1;
          end else if (byte_valid) begin
            asm_word <= next_word;
            byte_cnt <= byte_cnt + 1'b1;
            // Bus registers load here so the strobe is live during WRITE.
            if (byte_cnt == 2'd3) begin
              loader_state <= LOADER_WRITE;
              wen          <= 1'b1;
              addr_q       <= word_addr(BASE_ADDR, word_idx);
              data_q       <= next_word;
            end
          end
        end
        LOADER_WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (word_idx + 32'd1 == len_n) begin
            loader_state <= LOADER_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            loader_state <= LOADER_DATA;
          end
        end
        default: begin
          loader_state <= LOADER_IDLE;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
